test_simple_checker: RTL and testbench

Self-checking stimulus/response driver for the `test_simple` placement-and-routing gate-mix circuit; it is the opposite end of that circuit's pins. It drives `a`/`b`/`c`, samples `out1`/`out2`, and compares them cycle-by-cycle against an internal model of the circuit's AND/OR/XOR/DFF/NOT path. It then reports an error count and a pass flag. It sits beside the circuit under test in the same placed netlist, so post-route correctness can be checked in-world without external equipment.

---
 rtl/test_simple_checker_if.sv | 11 +
 rtl/test_simple_checker.sv | 110 +++++++++++
 tb/tb_test_simple_checker.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/test_simple_checker_if.sv
// Pin bundle between the checker (master side) and the test_simple gate-mix circuit (slave side).
interface test_simple_checker_if;
  logic a;
  logic b;
  logic c;
  logic out1;
  logic out2;

  modport master (output a, output b, output c, input out1, input out2);
  modport slave  (input a, input b, input c, output out1, output out2);
endinterface

// File: rtl/test_simple_checker.sv
// In-netlist stimulus/response checker for the test_simple gate-mix circuit: sweeps all eight
// {a,b,c} patterns PASSES times and counts cycles where out1/out2 disagree with the reference.
module test_simple_checker #(
  parameter int PASSES = 2,
  parameter int ERR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  test_simple_checker_if.master pins,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count
);
  localparam int SW_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        pat;
  logic [SW_W-1:0]   sweep;
  logic              exp_q;
  logic              chk_valid;
  logic              last_pat;
  logic              mismatch;
  logic [ERR_W-1:0]  err_nxt;

  function automatic logic model_x(input logic [2:0] p);
    return (p[2] & p[1]) ^ (p[1] | p[0]);
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign pins.a = pat[2];
  assign pins.b = pat[1];
  assign pins.c = pat[0];

  assign last_pat = (pat == 3'd7) && (sweep == SW_W'(PASSES - 1));

  // out1 pairs the DFF output with the a being driven now, not the a that produced exp_q.
  assign mismatch = chk_valid && ((pins.out2 != exp_q) || (pins.out1 != (~pat[2] & exp_q)));
  assign err_nxt  = mismatch ? sat_inc(err_count) : err_count;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_pat) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN) || (state_nxt == FLUSH);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat       <= 3'd0;
      sweep     <= '0;
      exp_q     <= 1'b0;
      chk_valid <= 1'b0;
      err_count <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pat       <= 3'd0;
            sweep     <= '0;
            chk_valid <= 1'b0;
            err_count <= '0;
            pass      <= 1'b0;
          end
        end
        RUN: begin
          exp_q     <= model_x(pat);
          chk_valid <= 1'b1;
          err_count <= err_nxt;
          // The final pattern stays on the pins through FLUSH so its response can be checked.
          if (!last_pat) begin
            pat <= pat + 3'd1;
            if (pat == 3'd7) sweep <= sweep + SW_W'(1);
          end
        end
        FLUSH: begin
          err_count <= err_nxt;
          pass      <= (err_nxt == '0);
          pat       <= 3'd0;
          chk_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_test_simple_checker.sv
// Bench for test_simple_checker: a fault-injectable model of the test_simple circuit sits on the
// pins of three checker instances (PASSES=2/ERR_W=4, PASSES=2/ERR_W=2, PASSES=1/ERR_W=4).
module tb_test_simple_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start0, start1, start2;
  logic       busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic [3:0] err0;
  logic [1:0] err1;
  logic [3:0] err2;
  logic [2:0] fmode0, fmode1, fmode2;
  logic [1:0] flip0, flip1, flip2;
  logic       q0, q1, q2;
  int         vectors = 0;
  int         miscompares = 0;

  test_simple_checker_if pins0();
  test_simple_checker_if pins1();
  test_simple_checker_if pins2();

  test_simple_checker #(.PASSES(2), .ERR_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .pins(pins0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0));
  test_simple_checker #(.PASSES(2), .ERR_W(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pins(pins1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1));
  test_simple_checker #(.PASSES(1), .ERR_W(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .pins(pins2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2));

  // Circuit model with fault hooks: 0 healthy, 1 out2 stuck 0, 2 both inverted,
  // 3 out1 stuck 0, 4 out1 stuck 1; flipN xors {out1,out2} on top of a healthy circuit.
  always_ff @(posedge clk) q0 <= (pins0.a & pins0.b) ^ (pins0.b | pins0.c);
  always_ff @(posedge clk) q1 <= (pins1.a & pins1.b) ^ (pins1.b | pins1.c);
  always_ff @(posedge clk) q2 <= (pins2.a & pins2.b) ^ (pins2.b | pins2.c);

  assign pins0.out2 = (fmode0 == 3'd1) ? 1'b0 : (fmode0 == 3'd2) ? ~q0 : q0 ^ flip0[0];
  assign pins0.out1 = (fmode0 == 3'd3) ? 1'b0 : (fmode0 == 3'd4) ? 1'b1 :
                      (fmode0 == 3'd2) ? ~(~pins0.a & q0) : (~pins0.a & q0) ^ flip0[1];
  assign pins1.out2 = (fmode1 == 3'd1) ? 1'b0 : (fmode1 == 3'd2) ? ~q1 : q1 ^ flip1[0];
  assign pins1.out1 = (fmode1 == 3'd3) ? 1'b0 : (fmode1 == 3'd4) ? 1'b1 :
                      (fmode1 == 3'd2) ? ~(~pins1.a & q1) : (~pins1.a & q1) ^ flip1[1];
  assign pins2.out2 = (fmode2 == 3'd1) ? 1'b0 : (fmode2 == 3'd2) ? ~q2 : q2 ^ flip2[0];
  assign pins2.out1 = (fmode2 == 3'd3) ? 1'b0 : (fmode2 == 3'd4) ? 1'b1 :
                      (fmode2 == 3'd2) ? ~(~pins2.a & q2) : (~pins2.a & q2) ^ flip2[1];

  typedef struct {
    logic [2:0] mode;
    int         exp_err;
    logic       exp_pass;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One run on instance 0. With dens>0, each busy cycle gets a random output flip with that
  // percentage; every busy cycle except the first is compared, so each flip there is one error.
  task automatic run0(input int dens, output int n_busy, output int n_err);
    int guard;
    logic [1:0] f;
    n_busy = 0;
    n_err  = 0;
    guard  = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    chk("start_busy", busy0, 1);
    chk("start_pattern", {pins0.a, pins0.b, pins0.c}, 0);
    while (!done0 && guard < 200) begin
      if (busy0) begin
        n_busy++;
        f = 2'b00;
        if (dens > 0 && $urandom_range(99) < dens) f = 2'($urandom_range(3, 1));
        flip0 = f;
        if (n_busy >= 2 && f != 2'b00) n_err++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    flip0 = 2'b00;
    chk("run_reached_done", done0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int nb, ne, guard, expv;
    logic [3:0] held_err;

    tbl[0] = '{3'd0, 0, 1'b1};
    tbl[1] = '{3'd1, 8, 1'b0};
    tbl[2] = '{3'd2, 15, 1'b0};
    tbl[3] = '{3'd3, 4, 1'b0};
    tbl[4] = '{3'd4, 12, 1'b0};

    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    fmode0 = 3'd0; fmode1 = 3'd0; fmode2 = 3'd0;
    flip0 = 2'b00; flip1 = 2'b00; flip2 = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_pass", pass0, 0);
    chk("reset_err", err0, 0);
    chk("reset_pins", {pins0.a, pins0.b, pins0.c}, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      fmode0 = tbl[i].mode;
      run0(0, nb, ne);
      chk($sformatf("tbl%0d_busy_cycles", i), nb, 17);
      chk($sformatf("tbl%0d_err", i), err0, tbl[i].exp_err);
      chk($sformatf("tbl%0d_pass", i), pass0, tbl[i].exp_pass);
      chk($sformatf("tbl%0d_idle_pins", i), {pins0.a, pins0.b, pins0.c}, 0);
    end

    // Results hold in DONE while start stays low.
    held_err = err0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done", done0, 1);
    chk("hold_err", err0, held_err);
    chk("hold_busy", busy0, 0);

    fmode0 = 3'd0;
    for (int r = 0; r < 6; r++) begin
      run0(int'($urandom_range(60, 5)), nb, ne);
      expv = (ne > 15) ? 15 : ne;
      chk($sformatf("rand%0d_busy_cycles", r), nb, 17);
      chk($sformatf("rand%0d_err", r), err0, expv);
      chk($sformatf("rand%0d_pass", r), pass0, (expv == 0) ? 1 : 0);
    end

    // Asynchronous reset in the middle of a faulty run, then a clean fresh run.
    fmode0 = 3'd2;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy0, 0);
    chk("midrst_done", done0, 0);
    chk("midrst_pass", pass0, 0);
    chk("midrst_err", err0, 0);
    chk("midrst_pins", {pins0.a, pins0.b, pins0.c}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_stays_idle", busy0, 0);
    fmode0 = 3'd1;
    run0(0, nb, ne);
    chk("after_rst_busy_cycles", nb, 17);
    chk("after_rst_err", err0, 8);

    // start held high: back-to-back runs, counter cleared at each restart.
    @(negedge clk);
    start0 = 1'b1;
    guard = 0;
    @(posedge clk);
    #1;
    while (!done0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("held_first_done", done0, 1);
    chk("held_first_err", err0, 8);
    @(posedge clk);
    #1;
    chk("held_restart_busy", busy0, 1);
    chk("held_restart_done", done0, 0);
    chk("held_restart_err", err0, 0);
    nb = 0;
    guard = 0;
    while (!done0 && guard < 100) begin
      if (busy0) nb++;
      @(posedge clk);
      #1;
      guard++;
    end
    start0 = 1'b0;
    chk("held_second_busy_cycles", nb, 17);
    chk("held_second_err", err0, 8);

    // ERR_W=2 instance: both outputs inverted saturates instead of wrapping.
    fmode1 = 3'd2;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    guard = 0;
    while (!done1 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("sat_done", done1, 1);
    chk("sat_err", err1, 3);
    chk("sat_pass", pass1, 0);

    // PASSES=1 instance: fault only on the FLUSH cycle (response to 111).
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    nb = 0;
    guard = 0;
    while (!done2 && guard < 100) begin
      if (busy2) begin
        nb++;
        if (nb == 9) begin
          chk("flush_pattern", {pins2.a, pins2.b, pins2.c}, 7);
          flip2 = 2'b11;
        end
      end
      @(posedge clk);
      #1;
      flip2 = 2'b00;
      guard++;
    end
    chk("flush_busy_cycles", nb, 9);
    chk("flush_done", done2, 1);
    chk("flush_err", err2, 1);
    chk("flush_pass", pass2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
